// File: rtl/pattern_gen_pkg.sv
// Shared LCD package: pattern mode encodings, colour-bar table, default
// panel/tile geometry and the per-axis bounce helper used by the cursor.
package pattern_gen_pkg;

    // Default 480x272 panel with 8x8 tiles.
    localparam int DEFAULT_H_ACTIVE  = 480;
    localparam int DEFAULT_V_ACTIVE  = 272;
    localparam int DEFAULT_TILE_LOG2 = 3;

    // Tile coordinates are carried on 7 bits (up to 128 tiles per axis).
    localparam int TILE_W = 7;

    // Number of vertical colour bars.
    localparam int BAR_COUNT = 8;

    typedef enum logic [1:0] {
        MODE_CHECKER = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_RASTER  = 2'd2,
        MODE_BOUNCE  = 2'd3
    } mode_e;

    // Bar colours as {r_on, g_on, b_on}; each lit channel is full scale.
    localparam logic [2:0] BAR_WHITE   = 3'b111;
    localparam logic [2:0] BAR_YELLOW  = 3'b110;
    localparam logic [2:0] BAR_CYAN    = 3'b011;
    localparam logic [2:0] BAR_GREEN   = 3'b010;
    localparam logic [2:0] BAR_MAGENTA = 3'b101;
    localparam logic [2:0] BAR_RED     = 3'b100;
    localparam logic [2:0] BAR_BLUE    = 3'b001;
    localparam logic [2:0] BAR_BLACK   = 3'b000;

    // One cursor axis: position plus direction (neg=1 means moving towards 0).
    typedef struct packed {
        logic [TILE_W-1:0] pos;
        logic              neg;
    } axis_t;

    // Bar index (left to right) to channel-enable mask.
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        logic [2:0] rgb;
        case (idx)
            3'd0:    rgb = BAR_WHITE;
            3'd1:    rgb = BAR_YELLOW;
            3'd2:    rgb = BAR_CYAN;
            3'd3:    rgb = BAR_GREEN;
            3'd4:    rgb = BAR_MAGENTA;
            3'd5:    rgb = BAR_RED;
            3'd6:    rgb = BAR_BLUE;
            default: rgb = BAR_BLACK;
        endcase
        return rgb;
    endfunction

    // One bounce step on a single axis over [0, max_pos]. A step that would
    // leave the range flips the direction and moves one step back inwards in
    // the same update. A position already beyond max_pos is pulled back to
    // max_pos and turned towards 0.
    function automatic axis_t bounce_step(input axis_t cur, input logic [TILE_W-1:0] max_pos);
        axis_t nxt;
        nxt = cur;
        if (max_pos == '0) begin
            // Single-tile axis: nowhere to move.
            nxt.pos = '0;
        end else if (cur.pos > max_pos) begin
            nxt.pos = max_pos;
            nxt.neg = 1'b1;
        end else if (!cur.neg) begin
            if (cur.pos == max_pos) begin
                nxt.pos = max_pos - 1'b1;
                nxt.neg = 1'b1;
            end else begin
                nxt.pos = cur.pos + 1'b1;
            end
        end else begin
            if (cur.pos == '0) begin
                nxt.pos = TILE_W'(1);
                nxt.neg = 1'b0;
            end else begin
                nxt.pos = cur.pos - 1'b1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pattern_gen_cursor_stepper.sv
// Cursor tile position for the raster and bouncing cursor patterns. The
// cursor moves at most one step per frame and only when stepping is enabled
// and the mode being selected at that frame start is a cursor mode.
module cursor_stepper
    import pattern_gen_pkg::*;
#(
    parameter int TX_COUNT = 60,
    parameter int TY_COUNT = 34
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              step_en,
    input  logic [1:0]        mode,
    output logic [TILE_W-1:0] tile_x,
    output logic [TILE_W-1:0] tile_y
);

    localparam logic [TILE_W-1:0] X_MAX = TILE_W'(TX_COUNT - 1);
    localparam logic [TILE_W-1:0] Y_MAX = TILE_W'(TY_COUNT - 1);

    axis_t cur_x, cur_y;
    axis_t nxt_x, nxt_y;
    mode_e step_mode;

    assign step_mode = mode_e'(mode);

    // Next cursor position: raster walk or bounce, else hold.
    always_comb begin
        nxt_x = cur_x;
        nxt_y = cur_y;
        if (frame_start && step_en) begin
            case (step_mode)
                MODE_RASTER: begin
                    // Directions are untouched in raster mode so a later
                    // switch to bounce continues with the old heading.
                    if (cur_x.pos >= X_MAX) begin
                        nxt_x.pos = '0;
                        nxt_y.pos = (cur_y.pos >= Y_MAX) ? '0 : cur_y.pos + 1'b1;
                    end else begin
                        nxt_x.pos = cur_x.pos + 1'b1;
                        nxt_y.pos = (cur_y.pos > Y_MAX) ? Y_MAX : cur_y.pos;
                    end
                end
                MODE_BOUNCE: begin
                    nxt_x = bounce_step(cur_x, X_MAX);
                    nxt_y = bounce_step(cur_y, Y_MAX);
                end
                default: begin
                    nxt_x = cur_x;
                    nxt_y = cur_y;
                end
            endcase
        end
    end

    // Cursor state register; reset puts the cursor at (0,0) heading +x/+y.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_x <= '0;
            cur_y <= '0;
        end else begin
            cur_x <= nxt_x;
            cur_y <= nxt_y;
        end
    end

    assign tile_x = cur_x.pos;
    assign tile_y = cur_y.pos;

endmodule

// File: rtl/pattern_gen.sv
// LCD test-pattern generator: checkerboard, colour bars and a tile cursor
// (raster or bouncing) over a checker background. Colour is produced in a
// two-register pipeline aligned with a delayed data-enable.
module pattern_gen
    import pattern_gen_pkg::*;
#(
    parameter int H_ACTIVE  = DEFAULT_H_ACTIVE,
    parameter int V_ACTIVE  = DEFAULT_V_ACTIVE,
    parameter int TILE_LOG2 = DEFAULT_TILE_LOG2,
    parameter int R_W       = 5,
    parameter int G_W       = 6,
    parameter int B_W       = 5,
    parameter int XY_W      = 10
) (
    input  logic            in_clk,
    input  logic            in_rst_n,
    input  logic [XY_W-1:0] in_pixelx,
    input  logic [XY_W-1:0] in_pixely,
    input  logic            in_de,
    input  logic            in_frame_start,
    input  logic [1:0]      in_mode,
    input  logic            in_step_en,
    output logic [R_W-1:0]  out_r,
    output logic [G_W-1:0]  out_g,
    output logic [B_W-1:0]  out_b,
    output logic            out_de,
    output logic [6:0]      out_tile_x,
    output logic [6:0]      out_tile_y
);

    // Tile grid; a partial bottom tile row still counts as a row.
    localparam int TX    = H_ACTIVE >> TILE_LOG2;
    localparam int TY    = (V_ACTIVE + (1 << TILE_LOG2) - 1) >> TILE_LOG2;
    localparam int BAR_W = H_ACTIVE / BAR_COUNT;

    localparam logic [R_W-1:0] R_HALF = {1'b0, {(R_W-1){1'b1}}};
    localparam logic [G_W-1:0] G_HALF = {1'b0, {(G_W-1){1'b1}}};
    localparam logic [B_W-1:0] B_HALF = {1'b0, {(B_W-1){1'b1}}};
    localparam logic [R_W-1:0] R_FULL = '1;
    localparam logic [G_W-1:0] G_FULL = '1;
    localparam logic [B_W-1:0] B_FULL = '1;

    mode_e             active_mode;
    logic [TILE_W-1:0] tile_x, tile_y;

    logic [XY_W-1:0]   px_tile_x, px_tile_y;
    logic              in_cursor;
    logic [2:0]        bar_idx;
    logic [2:0]        bar_mask;
    logic [R_W-1:0]    chk_r;
    logic [G_W-1:0]    chk_g;
    logic [B_W-1:0]    chk_b;
    logic [R_W-1:0]    pix_r;
    logic [G_W-1:0]    pix_g;
    logic [B_W-1:0]    pix_b;

    logic [R_W-1:0]    s1_r;
    logic [G_W-1:0]    s1_g;
    logic [B_W-1:0]    s1_b;
    logic              s1_de;

    // Mode only changes at a frame boundary. A pixel sampled on the same
    // edge as frame_start is coloured with the old mode because the colour
    // is computed from the register value before this update lands.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            active_mode <= MODE_CHECKER;
        end else if (in_frame_start) begin
            active_mode <= mode_e'(in_mode);
        end
    end

    cursor_stepper #(
        .TX_COUNT (TX),
        .TY_COUNT (TY)
    ) u_cursor_stepper (
        .clk         (in_clk),
        .rst_n       (in_rst_n),
        .frame_start (in_frame_start),
        .step_en     (in_step_en),
        .mode        (in_mode),
        .tile_x      (tile_x),
        .tile_y      (tile_y)
    );

    assign out_tile_x = tile_x;
    assign out_tile_y = tile_y;

    assign px_tile_x = in_pixelx >> TILE_LOG2;
    assign px_tile_y = in_pixely >> TILE_LOG2;
    assign in_cursor = (px_tile_x == XY_W'(tile_x)) && (px_tile_y == XY_W'(tile_y));

    // Checkerboard: each channel toggles at a different tile scale.
    always_comb begin
        chk_r = (in_pixelx[TILE_LOG2]   ^ in_pixely[TILE_LOG2])   ? R_HALF : '0;
        chk_g = (in_pixelx[TILE_LOG2+1] ^ in_pixely[TILE_LOG2+1]) ? G_HALF : '0;
        chk_b = (in_pixelx[TILE_LOG2+2] ^ in_pixely[TILE_LOG2+2]) ? B_HALF : '0;
    end

    // Bar index by threshold; anything past the seventh boundary is bar 7.
    always_comb begin
        bar_idx = 3'd0;
        for (int i = 1; i < BAR_COUNT; i++) begin
            if (int'(in_pixelx) >= i * BAR_W) begin
                bar_idx = 3'(i);
            end
        end
        bar_mask = bar_rgb(bar_idx);
    end

    // Pixel colour for the current sample, blanked outside the active area.
    always_comb begin
        pix_r = chk_r;
        pix_g = chk_g;
        pix_b = chk_b;
        case (active_mode)
            MODE_CHECKER: begin
                pix_r = chk_r;
                pix_g = chk_g;
                pix_b = chk_b;
            end
            MODE_BARS: begin
                pix_r = bar_mask[2] ? R_FULL : '0;
                pix_g = bar_mask[1] ? G_FULL : '0;
                pix_b = bar_mask[0] ? B_FULL : '0;
            end
            default: begin
                if (in_cursor) begin
                    pix_r = R_FULL;
                    pix_g = '0;
                    pix_b = '0;
                end
            end
        endcase
        if (!in_de) begin
            pix_r = '0;
            pix_g = '0;
            pix_b = '0;
        end
    end

    // First pipeline stage: colour and enable of the sampled pixel.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            s1_r  <= '0;
            s1_g  <= '0;
            s1_b  <= '0;
            s1_de <= 1'b0;
        end else begin
            s1_r  <= pix_r;
            s1_g  <= pix_g;
            s1_b  <= pix_b;
            s1_de <= in_de;
        end
    end

    // Output stage; colour is re-gated with the delayed enable it travels with.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            out_r  <= '0;
            out_g  <= '0;
            out_b  <= '0;
            out_de <= 1'b0;
        end else begin
            out_r  <= s1_de ? s1_r : '0;
            out_g  <= s1_de ? s1_g : '0;
            out_b  <= s1_de ? s1_b : '0;
            out_de <= s1_de;
        end
    end

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: reset, checker, bars, mode latching,
// raster and bounce cursor stepping, step hold and mid-line reset.
module tb_pattern_gen;

    logic       in_clk;
    logic       in_rst_n;
    logic [9:0] in_pixelx;
    logic [9:0] in_pixely;
    logic       in_de;
    logic       in_frame_start;
    logic [1:0] in_mode;
    logic       in_step_en;
    logic [4:0] out_r;
    logic [5:0] out_g;
    logic [4:0] out_b;
    logic       out_de;
    logic [6:0] out_tile_x;
    logic [6:0] out_tile_y;

    int n_compared;
    int n_mismatched;

    pattern_gen dut (
        .in_clk         (in_clk),
        .in_rst_n       (in_rst_n),
        .in_pixelx      (in_pixelx),
        .in_pixely      (in_pixely),
        .in_de          (in_de),
        .in_frame_start (in_frame_start),
        .in_mode        (in_mode),
        .in_step_en     (in_step_en),
        .out_r          (out_r),
        .out_g          (out_g),
        .out_b          (out_b),
        .out_de         (out_de),
        .out_tile_x     (out_tile_x),
        .out_tile_y     (out_tile_y)
    );

    // Clock: 10 time-unit period, inputs driven and outputs read on negedge.
    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    // Drive one pixel for one cycle and return what appears two cycles later.
    task automatic run_pixel(input logic [9:0] x, input logic [9:0] y, input logic de,
                             output logic [15:0] rgb, output logic de_o);
        @(negedge in_clk);
        in_pixelx = x;
        in_pixely = y;
        in_de     = de;
        @(negedge in_clk);
        in_de     = 1'b0;
        @(negedge in_clk);
        rgb  = {out_r, out_g, out_b};
        de_o = out_de;
    endtask

    // One frame_start pulse with the given mode and step enable.
    task automatic frame_pulse(input logic [1:0] m, input logic se);
        @(negedge in_clk);
        in_mode        = m;
        in_step_en     = se;
        in_frame_start = 1'b1;
        @(negedge in_clk);
        in_frame_start = 1'b0;
        in_step_en     = 1'b0;
    endtask

    task automatic test_reset;
        in_rst_n       = 1'b0;
        in_pixelx      = '0;
        in_pixely      = '0;
        in_de          = 1'b0;
        in_frame_start = 1'b0;
        in_mode        = 2'd0;
        in_step_en     = 1'b0;
        #1;
        n_compared++;
        if ({out_r, out_g, out_b, out_de, out_tile_x, out_tile_y} !== 31'd0) begin
            n_mismatched++;
            $display("FAIL reset_hold: got rgb=%h de=%b tile=(%0d,%0d) want all zero",
                     {out_r, out_g, out_b}, out_de, out_tile_x, out_tile_y);
        end
        repeat (3) @(negedge in_clk);
        in_rst_n = 1'b1;
        @(negedge in_clk);
        n_compared++;
        if ({out_r, out_g, out_b, out_de, out_tile_x, out_tile_y} !== 31'd0) begin
            n_mismatched++;
            $display("FAIL reset_release: got rgb=%h de=%b tile=(%0d,%0d) want all zero",
                     {out_r, out_g, out_b}, out_de, out_tile_x, out_tile_y);
        end
    endtask

    task automatic test_checker;
        logic [15:0] rgb;
        logic        de_o;
        frame_pulse(2'd0, 1'b0);
        run_pixel(10'd8, 10'd0, 1'b1, rgb, de_o);
        n_compared++;
        if ({rgb, de_o} !== {5'b01111, 6'b000000, 5'b00000, 1'b1}) begin
            n_mismatched++;
            $display("FAIL checker_8_0: got rgb=%b de=%b want 0111100000000000 de=1", rgb, de_o);
        end
        run_pixel(10'd16, 10'd0, 1'b1, rgb, de_o);
        n_compared++;
        if ({rgb, de_o} !== {5'b00000, 6'b011111, 5'b00000, 1'b1}) begin
            n_mismatched++;
            $display("FAIL checker_16_0: got rgb=%b de=%b want 0000001111100000 de=1", rgb, de_o);
        end
        run_pixel(10'd8, 10'd8, 1'b1, rgb, de_o);
        n_compared++;
        if ({rgb, de_o} !== {16'd0, 1'b1}) begin
            n_mismatched++;
            $display("FAIL checker_8_8: got rgb=%b de=%b want 0 de=1", rgb, de_o);
        end
        run_pixel(10'd32, 10'd0, 1'b1, rgb, de_o);
        n_compared++;
        if ({rgb, de_o} !== {5'b00000, 6'b000000, 5'b01111, 1'b1}) begin
            n_mismatched++;
            $display("FAIL checker_32_0: got rgb=%b de=%b want 0000000000001111 de=1", rgb, de_o);
        end
        run_pixel(10'd8, 10'd0, 1'b0, rgb, de_o);
        n_compared++;
        if ({rgb, de_o} !== 17'd0) begin
            n_mismatched++;
            $display("FAIL checker_blank: got rgb=%b de=%b want 0 de=0", rgb, de_o);
        end
    endtask

    task automatic test_bars;
        logic [15:0] rgb;
        logic        de_o;
        logic [9:0]  xs   [5];
        logic [15:0] exps [5];
        xs[0] = 10'd60;  exps[0] = {5'h1f, 6'h3f, 5'h00};  // yellow
        xs[1] = 10'd479; exps[1] = 16'h0000;               // black, last column
        xs[2] = 10'd0;   exps[2] = 16'hffff;               // white
        xs[3] = 10'd419; exps[3] = {5'h00, 6'h00, 5'h1f};  // blue, end of bar 6
        xs[4] = 10'd420; exps[4] = 16'h0000;               // black, start of bar 7
        frame_pulse(2'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            run_pixel(xs[i], 10'd5, 1'b1, rgb, de_o);
            n_compared++;
            if ({rgb, de_o} !== {exps[i], 1'b1}) begin
                n_mismatched++;
                $display("FAIL bars_x%0d: got rgb=%h de=%b want %h de=1", xs[i], rgb, de_o, exps[i]);
            end
        end
    endtask

    task automatic test_mode_latch;
        logic [15:0] rgb;
        logic        de_o;
        frame_pulse(2'd0, 1'b0);
        @(negedge in_clk);
        in_mode = 2'd1;
        run_pixel(10'd8, 10'd0, 1'b1, rgb, de_o);
        n_compared++;
        if (rgb !== {5'b01111, 11'd0}) begin
            n_mismatched++;
            $display("FAIL mode_midframe: got rgb=%h want %h", rgb, {5'b01111, 11'd0});
        end
        frame_pulse(2'd1, 1'b0);
        run_pixel(10'd60, 10'd0, 1'b1, rgb, de_o);
        n_compared++;
        if (rgb !== {5'h1f, 6'h3f, 5'h00}) begin
            n_mismatched++;
            $display("FAIL mode_after_fs: got rgb=%h want %h", rgb, {5'h1f, 6'h3f, 5'h00});
        end
        // frame_start together with an active pixel: that pixel keeps bars,
        // the following one is checker (x=60 sets bits 3,4,5).
        @(negedge in_clk);
        in_mode        = 2'd0;
        in_frame_start = 1'b1;
        in_pixelx      = 10'd60;
        in_pixely      = 10'd0;
        in_de          = 1'b1;
        @(negedge in_clk);
        in_frame_start = 1'b0;
        @(negedge in_clk);
        in_de = 1'b0;
        n_compared++;
        if ({out_r, out_g, out_b} !== {5'h1f, 6'h3f, 5'h00}) begin
            n_mismatched++;
            $display("FAIL fs_same_pixel: got rgb=%h want %h", {out_r, out_g, out_b}, {5'h1f, 6'h3f, 5'h00});
        end
        @(negedge in_clk);
        n_compared++;
        if ({out_r, out_g, out_b} !== {5'b01111, 6'b011111, 5'b01111}) begin
            n_mismatched++;
            $display("FAIL fs_next_pixel: got rgb=%h want %h", {out_r, out_g, out_b},
                     {5'b01111, 6'b011111, 5'b01111});
        end
    endtask

    task automatic test_raster;
        logic [15:0] rgb;
        logic        de_o;
        frame_pulse(2'd2, 1'b0);
        repeat (2039) frame_pulse(2'd2, 1'b1);
        n_compared++;
        if ({out_tile_x, out_tile_y} !== {7'd59, 7'd33}) begin
            n_mismatched++;
            $display("FAIL raster_last: got (%0d,%0d) want (59,33)", out_tile_x, out_tile_y);
        end
        frame_pulse(2'd2, 1'b1);
        n_compared++;
        if ({out_tile_x, out_tile_y} !== {7'd0, 7'd0}) begin
            n_mismatched++;
            $display("FAIL raster_wrap: got (%0d,%0d) want (0,0)", out_tile_x, out_tile_y);
        end
        frame_pulse(2'd2, 1'b1);
        n_compared++;
        if ({out_tile_x, out_tile_y} !== {7'd1, 7'd0}) begin
            n_mismatched++;
            $display("FAIL raster_next: got (%0d,%0d) want (1,0)", out_tile_x, out_tile_y);
        end
        run_pixel(10'd8, 10'd0, 1'b1, rgb, de_o);
        n_compared++;
        if (rgb !== {5'h1f, 11'd0}) begin
            n_mismatched++;
            $display("FAIL cursor_pixel: got rgb=%h want %h", rgb, {5'h1f, 11'd0});
        end
        run_pixel(10'd16, 10'd0, 1'b1, rgb, de_o);
        n_compared++;
        if (rgb !== {5'h00, 6'b011111, 5'h00}) begin
            n_mismatched++;
            $display("FAIL cursor_background: got rgb=%h want %h", rgb, {5'h00, 6'b011111, 5'h00});
        end
    endtask

    task automatic test_bounce;
        logic [15:0] rgb;
        logic        de_o;
        repeat (658) frame_pulse(2'd2, 1'b1);
        n_compared++;
        if ({out_tile_x, out_tile_y} !== {7'd59, 7'd10}) begin
            n_mismatched++;
            $display("FAIL bounce_setup: got (%0d,%0d) want (59,10)", out_tile_x, out_tile_y);
        end
        frame_pulse(2'd3, 1'b0);
        frame_pulse(2'd3, 1'b1);
        n_compared++;
        if ({out_tile_x, out_tile_y} !== {7'd58, 7'd11}) begin
            n_mismatched++;
            $display("FAIL bounce_x_edge: got (%0d,%0d) want (58,11)", out_tile_x, out_tile_y);
        end
        repeat (23) frame_pulse(2'd3, 1'b1);
        n_compared++;
        if ({out_tile_x, out_tile_y} !== {7'd35, 7'd32}) begin
            n_mismatched++;
            $display("FAIL bounce_y_edge: got (%0d,%0d) want (35,32)", out_tile_x, out_tile_y);
        end
        // Both directions are now -1; raster back to the origin keeping them.
        frame_pulse(2'd2, 1'b0);
        repeat (85) frame_pulse(2'd2, 1'b1);
        frame_pulse(2'd3, 1'b0);
        frame_pulse(2'd3, 1'b1);
        n_compared++;
        if ({out_tile_x, out_tile_y} !== {7'd1, 7'd1}) begin
            n_mismatched++;
            $display("FAIL bounce_corner: got (%0d,%0d) want (1,1)", out_tile_x, out_tile_y);
        end
        run_pixel(10'd8, 10'd8, 1'b1, rgb, de_o);
        n_compared++;
        if (rgb !== {5'h1f, 11'd0}) begin
            n_mismatched++;
            $display("FAIL bounce_cursor_pixel: got rgb=%h want %h", rgb, {5'h1f, 11'd0});
        end
    endtask

    task automatic test_step_hold;
        frame_pulse(2'd3, 1'b0);
        n_compared++;
        if ({out_tile_x, out_tile_y} !== {7'd1, 7'd1}) begin
            n_mismatched++;
            $display("FAIL hold_step_en0: got (%0d,%0d) want (1,1)", out_tile_x, out_tile_y);
        end
        frame_pulse(2'd0, 1'b1);
        n_compared++;
        if ({out_tile_x, out_tile_y} !== {7'd1, 7'd1}) begin
            n_mismatched++;
            $display("FAIL hold_mode0: got (%0d,%0d) want (1,1)", out_tile_x, out_tile_y);
        end
    endtask

    task automatic test_reset_midline;
        frame_pulse(2'd3, 1'b0);
        @(negedge in_clk);
        in_pixelx = 10'd8;
        in_pixely = 10'd8;
        in_de     = 1'b1;
        repeat (2) @(negedge in_clk);
        n_compared++;
        if ({out_r, out_g, out_b, out_de} !== {5'h1f, 11'd0, 1'b1}) begin
            n_mismatched++;
            $display("FAIL pre_reset: got rgb=%h de=%b want %h de=1", {out_r, out_g, out_b}, out_de, {5'h1f, 11'd0});
        end
        #2 in_rst_n = 1'b0;
        #1;
        n_compared++;
        if ({out_r, out_g, out_b, out_de, out_tile_x, out_tile_y} !== 31'd0) begin
            n_mismatched++;
            $display("FAIL async_reset: got rgb=%h de=%b tile=(%0d,%0d) want all zero",
                     {out_r, out_g, out_b}, out_de, out_tile_x, out_tile_y);
        end
        @(negedge in_clk);
        in_pixelx = 10'd8;
        in_pixely = 10'd0;
        in_rst_n  = 1'b1;
        repeat (2) @(negedge in_clk);
        in_de = 1'b0;
        n_compared++;
        if ({out_r, out_g, out_b, out_de, out_tile_x, out_tile_y} !== {5'b01111, 11'd0, 1'b1, 14'd0}) begin
            n_mismatched++;
            $display("FAIL post_reset: got rgb=%h de=%b tile=(%0d,%0d) want %h de=1 tile=(0,0)",
                     {out_r, out_g, out_b}, out_de, out_tile_x, out_tile_y, {5'b01111, 11'd0});
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        test_reset();
        test_checker();
        test_bars();
        test_mode_latch();
        test_raster();
        test_bounce();
        test_step_hold();
        test_reset_midline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/pattern_gen.md
PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 Parameter H_ACTIVE, 480, active pixels per line.
REQ-002 Parameter V_ACTIVE, 272, active lines per frame.
REQ-003 Parameter TILE_LOG2, 3, log2 of the square tile edge in pixels.
REQ-004 Parameters R_W/G_W/B_W, 5/6/5, colour channel widths.
REQ-005 Parameter XY_W, 10, pixel coordinate width.
REQ-006 in_clk  input  1  pixel clock; the only clock.
REQ-007 in_rst_n  input  1  reset, asynchronous, active-low.
REQ-008 in_pixelx  input  XY_W  current pixel column from the LCD timing block.
REQ-009 in_pixely  input  XY_W  current pixel row.
REQ-010 in_de  input  1  pixel is in the active area.
REQ-011 in_frame_start  input  1  one-cycle pulse per frame, synchronous to in_clk.
REQ-012 in_mode  input  2  pattern select: 0 checker, 1 colour bars, 2 raster cursor, 3 bouncing cursor.
REQ-013 in_step_en  input  1  cursor advances on frame_start only when high.
REQ-014 out_r/out_g/out_b  output  R_W/G_W/B_W  pixel colour, registered.
REQ-015 out_de  output  1  in_de delayed to align with the colour outputs.
REQ-016 out_tile_x/out_tile_y  output  7/7  current cursor tile coordinates.

Function
REQ-017 Tile counts: TX = H_ACTIVE>>TILE_LOG2 (60) and TY = ceil(V_ACTIVE/2^TILE_LOG2) (34), computed at elaboration.
REQ-018 Latency: colour and out_de are valid exactly 2 in_clk cycles after the in_pixelx/in_pixely/in_de sample.
REQ-019 Colour outputs are forced to 0 in any cycle where the delayed de is 0.
REQ-020 in_mode is sampled into an active-mode register only on in_frame_start; mid-frame changes have no effect until then.
REQ-021 Mode 0: r = half scale if x[T]^y[T], g = half scale if x[T+1]^y[T+1], b = half scale if x[T+2]^y[T+2], else 0; T = TILE_LOG2. Half scale = MSB clear, all other bits set.
REQ-022 Mode 1: eight vertical bars of width H_ACTIVE/8 (integer); colours white, yellow, cyan, green, magenta, red, blue, black at full scale; columns at or beyond 7*(H_ACTIVE/8) use bar 7.
REQ-023 Modes 2/3: mode-0 background; pixels inside cursor tile (x>>T == tile_x and y>>T == tile_y) show full-scale red, g=b=0.
REQ-024 Cursor moves one step per in_frame_start with in_step_en=1 in modes 2 and 3; otherwise it holds.
REQ-025 Raster stepping (mode 2): x+1; at x==TX-1, x becomes 0 and y increments; at x==TX-1 and y==TY-1, both become 0.
REQ-026 Bounce stepping (mode 3): directions dx, dy in {+1,-1}; when a step would leave [0,TX-1] (resp. [0,TY-1]) the direction flips and the position moves one step the opposite way in the same update; at corners both axes flip together.
REQ-027 Entering mode 2 or 3 keeps the current cursor position; a position out of range (after a parameter change) is clamped to range on the next step.
REQ-028 in_frame_start coinciding with in_de=1 is legal; the new mode and cursor apply from the next pixel sample.

Reset
REQ-029 On in_rst_n low, all outputs, pipeline stages and cursor state clear asynchronously: colours 0, out_de 0, tile (0,0), dx=dy=+1, active mode 0.
REQ-030 Reset deassertion mid-frame resumes output from the next sample with no partial-state artefact.

Structure
REQ-031 Mode encodings, bar colour constants and the default tile geometry live in the shared LCD package.
REQ-032 The cursor stepping logic (REQ-024..027) is a sub-module named cursor_stepper; the colour pipeline stays in pattern_gen.

Verification
REQ-033 Reset, mode 0, pixel (8,0) de=1 -> two cycles later r=01111, g=0, b=0, out_de=1.
REQ-034 Mode 1, pixel x=60 then x=479 -> yellow (11111,111111,00000) then black.
REQ-035 Mode 2, tile (59,33), one frame_start with step_en=1 -> tile (0,0); second frame_start -> (1,0).
REQ-036 Mode 3, tile (59,10) dx=+1 dy=+1, frame_start -> tile (58,11); from (0,0) with dx=dy=-1 -> (1,1).
REQ-037 in_mode changed 0->1 mid-frame -> output stays mode 0 until next frame_start, then bars.
REQ-038 in_rst_n pulsed low mid-line -> outputs 0 the same cycle; tile (0,0) after release.
